// File: rtl/branch_hazard_unit_if.sv
// Decode-side bus of the branch hazard unit.
// The decode stage (master) presents the instruction fields and the global
// freeze. The hazard unit (slave) returns stall/bubble and the stall counter.

`ifndef OPCODE_SIZE
`define OPCODE_SIZE 7
`endif
`ifndef REGFILE_LOGSIZE
`define REGFILE_LOGSIZE 5
`endif

interface branch_hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [`OPCODE_SIZE-1:0]     opcode;
    logic [`REGFILE_LOGSIZE-1:0] rs1_field;
    logic [`REGFILE_LOGSIZE-1:0] rs2_field;
    logic [`REGFILE_LOGSIZE-1:0] wr_field;
    logic                        wr_en;
    logic                        ext_stall;
    logic                        stall;
    logic                        bubble;
    logic [CNT_W-1:0]            stall_cnt;

    modport master (
        output opcode,
        output rs1_field,
        output rs2_field,
        output wr_field,
        output wr_en,
        output ext_stall,
        input  stall,
        input  bubble,
        input  stall_cnt
    );

    modport slave (
        input  opcode,
        input  rs1_field,
        input  rs2_field,
        input  wr_field,
        input  wr_en,
        input  ext_stall,
        output stall,
        output bubble,
        output stall_cnt
    );
endinterface

// File: rtl/branch_hazard_unit.sv
// Decode-stage hazard detector for the 5-stage RV32I pipeline.
// Branches and jalr resolve in decode, so their operands must be available
// from MEM at the latest (via the branch forwarding unit). Producers still in
// EX, or loads still in MEM, force a stall of fetch/decode plus an EX bubble.
// Non-branch instructions only stall on the classic load-use case.
// The only state is a shadow copy of the EX and MEM destination registers;
// multi-cycle stalls fall out of bubbles moving from EX into MEM.

`ifndef OPCODE_SIZE
`define OPCODE_SIZE 7
`endif
`ifndef REGFILE_LOGSIZE
`define REGFILE_LOGSIZE 5
`endif
`ifndef BTYPE_OP
`define BTYPE_OP 7'b1100011
`endif
`ifndef JALR_OP
`define JALR_OP 7'b1100111
`endif
`ifndef LOAD_OP
`define LOAD_OP 7'b0000011
`endif
`ifndef STORE_OP
`define STORE_OP 7'b0100011
`endif
`ifndef RTYPE_OP
`define RTYPE_OP 7'b0110011
`endif
`ifndef ITYPE_OP
`define ITYPE_OP 7'b0010011
`endif

module branch_hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    branch_hazard_unit_if.slave   bus
);

    localparam int RW = `REGFILE_LOGSIZE;

    // Shadow copies of the destination info of the instructions in EX and MEM
    logic          ex_wr_en;
    logic [RW-1:0] ex_wr_field;
    logic          ex_is_load;
    logic          mem_wr_en;
    logic [RW-1:0] mem_wr_field;
    logic          mem_is_load;
    logic [CNT_W-1:0] stall_cnt_q;

    // Decode-side classification of the instruction
    logic rs1_used;
    logic rs2_used;
    logic is_branch;
    logic dec_is_load;
    logic dec_writes;

    // Operand match terms against EX and MEM
    logic hex_1;
    logic hex_2;
    logic hmem_1;
    logic hmem_2;
    logic hazard;

    // Work out which source operands the decode instruction actually reads
    always_comb begin
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        is_branch   = 1'b0;
        dec_is_load = 1'b0;
        case (bus.opcode)
            `BTYPE_OP: begin
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                is_branch = 1'b1;
            end
            `JALR_OP: begin
                rs1_used  = 1'b1;
                is_branch = 1'b1;
            end
            `LOAD_OP: begin
                rs1_used    = 1'b1;
                dec_is_load = 1'b1;
            end
            `STORE_OP: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            `RTYPE_OP: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            `ITYPE_OP: begin
                rs1_used = 1'b1;
            end
            default: begin
                rs1_used = 1'b0;
                rs2_used = 1'b0;
            end
        endcase
        // x0 writes are discarded so they can never match a later reader
        dec_writes = bus.wr_en && (bus.wr_field != '0);
    end

    // Compare each used, non-zero source register against EX and MEM writers
    always_comb begin
        hex_1  = rs1_used && (bus.rs1_field != '0) && ex_wr_en
                 && (ex_wr_field == bus.rs1_field);
        hex_2  = rs2_used && (bus.rs2_field != '0) && ex_wr_en
                 && (ex_wr_field == bus.rs2_field);
        hmem_1 = rs1_used && (bus.rs1_field != '0) && mem_wr_en
                 && (mem_wr_field == bus.rs1_field);
        hmem_2 = rs2_used && (bus.rs2_field != '0) && mem_wr_en
                 && (mem_wr_field == bus.rs2_field);
    end

    // Branches need the value by MEM and not from a load; others only fear a load in EX
    always_comb begin
        hazard = 1'b0;
        if (is_branch) begin
            if (hex_1 || hex_2) begin
                hazard = 1'b1;
            end
            if ((hmem_1 || hmem_2) && mem_is_load) begin
                hazard = 1'b1;
            end
        end else begin
            if ((hex_1 || hex_2) && ex_is_load) begin
                hazard = 1'b1;
            end
        end
    end

    // Stall is raised even during a freeze; the bubble only when the pipe moves
    always_comb begin
        bus.stall     = hazard;
        bus.bubble    = hazard && !bus.ext_stall;
        bus.stall_cnt = stall_cnt_q;
    end

    // Advance the EX/MEM shadow regs with the pipeline, inserting bubbles on hazards
    always_ff @(posedge clk) begin
        if (!nrst) begin
            ex_wr_en     <= 1'b0;
            ex_wr_field  <= '0;
            ex_is_load   <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_wr_field <= '0;
            mem_is_load  <= 1'b0;
        end else if (!bus.ext_stall) begin
            mem_wr_en    <= ex_wr_en;
            mem_wr_field <= ex_wr_field;
            mem_is_load  <= ex_is_load;
            if (bus.bubble) begin
                ex_wr_en    <= 1'b0;
                ex_wr_field <= '0;
                ex_is_load  <= 1'b0;
            end else begin
                ex_wr_en    <= dec_writes;
                ex_wr_field <= bus.wr_field;
                ex_is_load  <= dec_is_load;
            end
        end
    end

    // Count cycles lost to this unit, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!nrst) begin
            stall_cnt_q <= '0;
        end else if (!bus.ext_stall && bus.bubble && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Testbench for branch_hazard_unit.
// Two instances share clock, reset and decode stimulus: a 16-bit counter
// instance checked throughout and a 4-bit counter instance for saturation.

`ifndef OPCODE_SIZE
`define OPCODE_SIZE 7
`endif
`ifndef REGFILE_LOGSIZE
`define REGFILE_LOGSIZE 5
`endif

module tb_branch_hazard_unit;

    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic        ext;
        logic        es;
        logic        eb;
        logic [15:0] ecnt;
    } vec_t;

    logic clk;
    logic nrst;
    int   total;
    int   bad;
    vec_t sb[$];

    branch_hazard_unit_if #(.CNT_W(16)) bus16 ();
    branch_hazard_unit_if #(.CNT_W(4))  bus4 ();

    branch_hazard_unit #(.CNT_W(16)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus16.slave)
    );

    branch_hazard_unit #(.CNT_W(4)) dut4 (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [6:0] op, input int rs1, input int rs2,
                                input int rd, input logic wen, input logic ext,
                                input logic es, input logic eb, input int ecnt);
        vec_t v;
        v.op   = op;
        v.rs1  = 5'(rs1);
        v.rs2  = 5'(rs2);
        v.rd   = 5'(rd);
        v.wen  = wen;
        v.ext  = ext;
        v.es   = es;
        v.eb   = eb;
        v.ecnt = 16'(ecnt);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus16.opcode    = v.op;
        bus16.rs1_field = v.rs1;
        bus16.rs2_field = v.rs2;
        bus16.wr_field  = v.rd;
        bus16.wr_en     = v.wen;
        bus16.ext_stall = v.ext;
        bus4.opcode     = v.op;
        bus4.rs1_field  = v.rs1;
        bus4.rs2_field  = v.rs2;
        bus4.wr_field   = v.rd;
        bus4.wr_en      = v.wen;
        bus4.ext_stall  = v.ext;
    endtask

    // Present one decode instruction at the falling edge and queue its expectation
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        drive(v);
        sb.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        drive(mk(OP_I, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({bus16.stall, bus16.bubble} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got stall/bubble=%b need 00", {bus16.stall, bus16.bubble});
        end
        total++;
        if (bus16.stall_cnt !== 16'd0) begin
            bad++;
            $display("[TB] FAIL reset_cnt16: got %0d need 0", bus16.stall_cnt);
        end
        total++;
        if (bus4.stall_cnt !== 4'd0) begin
            bad++;
            $display("[TB] FAIL reset_cnt4: got %0d need 0", bus4.stall_cnt);
        end
    endtask

    // Run a table of decode cycles: each row is driven, then popped and compared
    task automatic test_sequence(input string name, input vec_t rows[$]);
        vec_t e;
        do_reset();
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            #1;
            e = sb.pop_front();
            total++;
            if ({bus16.stall, bus16.bubble} !== {e.es, e.eb}) begin
                bad++;
                $display("[TB] FAIL %s row%0d stall/bubble: got %b need %b",
                         name, i, {bus16.stall, bus16.bubble}, {e.es, e.eb});
            end
            total++;
            if (bus16.stall_cnt !== e.ecnt) begin
                bad++;
                $display("[TB] FAIL %s row%0d stall_cnt: got %0d need %0d",
                         name, i, bus16.stall_cnt, e.ecnt);
            end
        end
    endtask

    task automatic test_alu_branch();
        vec_t r[$];
        r.push_back(mk(OP_I, 2, 0, 1, 1, 0, 0, 0, 0));   // addi x1,x2,3
        r.push_back(mk(OP_B, 1, 5, 0, 0, 0, 1, 1, 0));   // beq x1,x5
        r.push_back(mk(OP_B, 1, 5, 0, 0, 0, 0, 0, 1));
        r.push_back(mk(OP_JALR, 1, 0, 3, 1, 0, 0, 0, 1)); // jalr reads x1 from beq (no write)
        test_sequence("alu_branch", r);
    endtask

    task automatic test_load_branch();
        vec_t r[$];
        r.push_back(mk(OP_LD, 2, 0, 1, 1, 0, 0, 0, 0));  // lw x1
        r.push_back(mk(OP_B, 1, 5, 0, 0, 0, 1, 1, 0));
        r.push_back(mk(OP_B, 1, 5, 0, 0, 0, 1, 1, 1));
        r.push_back(mk(OP_B, 1, 5, 0, 0, 0, 0, 0, 2));
        test_sequence("load_branch", r);
    endtask

    task automatic test_load_use();
        vec_t r[$];
        r.push_back(mk(OP_LD, 2, 0, 1, 1, 0, 0, 0, 0));  // lw x1
        r.push_back(mk(OP_R, 1, 3, 2, 1, 0, 1, 1, 0));   // add x2,x1,x3
        r.push_back(mk(OP_R, 1, 3, 2, 1, 0, 0, 0, 1));
        test_sequence("load_use", r);
        r.delete();
        r.push_back(mk(OP_LD, 2, 0, 1, 1, 0, 0, 0, 0));  // lw x1
        r.push_back(mk(OP_I, 0, 0, 0, 0, 0, 0, 0, 0));   // nop
        r.push_back(mk(OP_B, 5, 1, 0, 0, 0, 1, 1, 0));   // beq x5,x1
        r.push_back(mk(OP_B, 5, 1, 0, 0, 0, 0, 0, 1));
        test_sequence("load_nop_branch", r);
        r.delete();
        r.push_back(mk(OP_I, 2, 0, 1, 1, 0, 0, 0, 0));   // addi x1
        r.push_back(mk(OP_I, 0, 0, 0, 0, 0, 0, 0, 0));   // nop
        r.push_back(mk(OP_B, 1, 6, 0, 0, 0, 0, 0, 0));   // beq x1,x6
        test_sequence("alu_nop_branch", r);
    endtask

    task automatic test_boundaries();
        vec_t r[$];
        r.push_back(mk(OP_I, 0, 0, 0, 1, 0, 0, 0, 0));   // addi x0,x0,1
        r.push_back(mk(OP_B, 0, 0, 0, 0, 0, 0, 0, 0));   // beq x0,x0
        test_sequence("x0_operand", r);
        r.delete();
        r.push_back(mk(OP_LD, 2, 0, 1, 1, 0, 0, 0, 0));  // lw x1
        r.push_back(mk(OP_ST, 3, 1, 0, 0, 0, 1, 1, 0));  // sw x1,0(x3)
        r.push_back(mk(OP_ST, 3, 1, 0, 0, 0, 0, 0, 1));
        test_sequence("store_rs2", r);
    endtask

    task automatic test_freeze();
        vec_t r[$];
        r.push_back(mk(OP_LD, 2, 0, 1, 1, 0, 0, 0, 0));  // lw x1
        for (int k = 0; k < 3; k++) begin
            r.push_back(mk(OP_R, 1, 3, 2, 1, 1, 1, 0, 0));
        end
        r.push_back(mk(OP_R, 1, 3, 2, 1, 0, 1, 1, 0));
        r.push_back(mk(OP_R, 1, 3, 2, 1, 0, 0, 0, 1));
        test_sequence("freeze", r);
    endtask

    task automatic test_reset_mid_stall();
        vec_t e;
        do_reset();
        applyStimulus(mk(OP_LD, 2, 0, 1, 1, 0, 0, 0, 0));
        #1;
        e = sb.pop_front();
        applyStimulus(mk(OP_B, 1, 5, 0, 0, 0, 1, 1, 0));
        #1;
        e = sb.pop_front();
        total++;
        if ({bus16.stall, bus16.bubble} !== {e.es, e.eb}) begin
            bad++;
            $display("[TB] FAIL mid_stall_first: got %b need %b", {bus16.stall, bus16.bubble}, {e.es, e.eb});
        end
        @(negedge clk);
        nrst = 1'b0;
        #1;
        total++;
        if (bus16.stall_cnt !== 16'd1) begin
            bad++;
            $display("[TB] FAIL mid_stall_cnt: got %0d need 1", bus16.stall_cnt);
        end
        @(negedge clk);
        nrst = 1'b1;
        #1;
        total++;
        if (bus16.stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_stall_reset_stall: got %b need 0", bus16.stall);
        end
        total++;
        if (bus16.stall_cnt !== 16'd0) begin
            bad++;
            $display("[TB] FAIL mid_stall_reset_cnt: got %0d need 0", bus16.stall_cnt);
        end
    endtask

    task automatic test_saturate();
        vec_t e;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(mk(OP_I, 2, 0, 1, 1, 0, 0, 0, i));
            applyStimulus(mk(OP_B, 1, 5, 0, 0, 0, 1, 1, i));
            applyStimulus(mk(OP_B, 1, 5, 0, 0, 0, 0, 0, i + 1));
            #1;
            while (sb.size() > 1) e = sb.pop_front();
            e = sb.pop_front();
            total++;
            if ({bus16.stall, bus16.bubble, bus16.stall_cnt} !== {e.es, e.eb, e.ecnt}) begin
                bad++;
                $display("[TB] FAIL saturate_iter%0d: got %b/%0d need %b/%0d", i,
                         {bus16.stall, bus16.bubble}, bus16.stall_cnt, {e.es, e.eb}, e.ecnt);
            end
        end
        total++;
        if (bus4.stall_cnt !== 4'd15) begin
            bad++;
            $display("[TB] FAIL saturate_cnt4: got %0d need 15", bus4.stall_cnt);
        end
        total++;
        if (bus16.stall_cnt !== 16'd20) begin
            bad++;
            $display("[TB] FAIL saturate_cnt16: got %0d need 20", bus16.stall_cnt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nrst  = 1'b0;
        drive(mk(OP_I, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        test_reset();
        test_alu_branch();
        test_load_branch();
        test_load_use();
        test_boundaries();
        test_freeze();
        test_reset_mid_stall();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout need completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
